// File: rtl/pair_serializer.sv
// Operand-pair serializer: buffers (A,B) pairs in a small FIFO and emits them
// as a word stream A then B, with out_last flagging the B word.
module pair_serializer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pair_valid,
  output logic                       pair_ready,
  input  logic [DATA_W-1:0]          pair_a,
  input  logic [DATA_W-1:0]          pair_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     pair_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_mem_a [DEPTH];
  logic [DATA_W-1:0]   r_mem_b [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [DATA_W-1:0]   r_out_data;
  logic [DATA_W-1:0]   r_hold_b;
  logic                r_out_last;
  logic                w_push;
  logic                w_pop;
  logic                w_fifo_nonempty;

  assign pair_ready      = (r_count != CW'(DEPTH));
  assign w_push          = pair_valid && pair_ready;
  assign w_fifo_nonempty = (r_count != '0);

  assign out_valid  = (r_state != IDLE);
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign pair_count = r_count;

  // Pop decisions see the count before this edge's push, so a pair written
  // into an empty FIFO is never forwarded on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fifo_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND_A;
        end
      end
      SEND_A: begin
        if (out_ready) w_state_nxt = SEND_B;
      end
      SEND_B: begin
        if (out_ready) begin
          if (w_fifo_nonempty) begin
            w_pop       = 1'b1;
            w_state_nxt = SEND_A;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= pair_a;
      r_mem_b[r_wr_ptr] <= pair_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_hold_b   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;

      if (w_pop) begin
        r_out_data <= r_mem_a[r_rd_ptr];
        r_hold_b   <= r_mem_b[r_rd_ptr];
        r_out_last <= 1'b0;
      end else if (r_state == SEND_A && out_ready) begin
        r_out_data <= r_hold_b;
        r_out_last <= 1'b1;
      end else if (r_state == SEND_B && out_ready) begin
        r_out_last <= 1'b0;
      end
    end
  end

endmodule
